// File: rtl/hd_pkg.sv
// Shared constants and width helpers for the hd_rr_arbiter slice.
package hd_pkg;

    localparam int unsigned HD_DATA_WIDTH = 32;

    // Widest requester index for the legal NUM_REQ range (up to 16).
    typedef logic [3:0] hd_idx_max_t;

    function automatic int unsigned hd_clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r = r + 1;
        return r;
    endfunction

    function automatic int unsigned hd_idx_w(input int unsigned n);
        return (hd_clog2(n) < 1) ? 1 : hd_clog2(n);
    endfunction

endpackage

// File: rtl/hd_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after i_ptr, wrapping.
module hd_rr_pick
    import hd_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]           i_req,
    input  logic [hd_idx_w(NUM_REQ)-1:0] i_ptr,
    output logic [NUM_REQ-1:0]           o_gnt,
    output logic [hd_idx_w(NUM_REQ)-1:0] o_idx,
    output logic                         o_any
);

    localparam int unsigned IDX_W = hd_idx_w(NUM_REQ);

    logic [NUM_REQ-1:0]   w_mask;
    logic [2*NUM_REQ-1:0] w_dbl;
    int unsigned          w_pos;

    // Lower half holds requests at/after ptr, upper half the full vector, so the
    // lowest set bit of the concatenation is the wrapped winner.
    always_comb begin
        w_mask = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_mask[i] = (i >= 32'(i_ptr));
        end
        w_dbl = {i_req, i_req & w_mask};

        o_any = 1'b0;
        w_pos = 0;
        for (int unsigned i = 0; i < 2 * NUM_REQ; i++) begin
            if (!o_any && w_dbl[i]) begin
                o_any = 1'b1;
                w_pos = i;
            end
        end

        o_idx = (w_pos >= NUM_REQ) ? IDX_W'(w_pos - NUM_REQ) : IDX_W'(w_pos);

        o_gnt = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            o_gnt[i] = o_any && ((w_pos == i) || (w_pos == i + NUM_REQ));
        end
    end

endmodule

// File: rtl/hd_rr_arbiter.sv
// Round-robin merge of NUM_REQ valid/ready streams into one registered output.
// Optional burst mode (up to MAX_BURST beats per grant) via `define HD_ARB_BURST_EN.
module hd_rr_arbiter
    import hd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = HD_DATA_WIDTH,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [hd_idx_w(NUM_REQ)-1:0]  out_src,
    input  logic                          out_ready
);

    localparam int unsigned            IDX_W    = hd_idx_w(NUM_REQ);
    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [IDX_W-1:0]      r_out_src;
    logic [IDX_W-1:0]      r_ptr;

    logic                  w_load;
    logic                  w_any;
    logic [NUM_REQ-1:0]    w_gnt;
    logic [IDX_W-1:0]      w_idx;
    logic [IDX_W-1:0]      w_next_idx;
    logic [DATA_WIDTH-1:0] w_win_data;

    hd_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_load = !r_out_valid || out_ready;

    always_comb begin
        w_next_idx = (w_idx == LAST_IDX) ? '0 : w_idx + 1'b1;
        w_win_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) w_win_data = w_win_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
        req_ready = (w_load && !rst) ? w_gnt : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
        end else if (w_load) begin
            r_out_valid <= w_any;
            if (w_any) begin
                r_out_data <= w_win_data;
                r_out_src  <= w_idx;
            end
        end
    end

`ifdef HD_ARB_BURST_EN
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    logic [7:0]       r_cnt;
    logic [7:0]       w_cnt_base;
    logic [IDX_W-1:0] w_ptr_inc;

    // A winner other than ptr means ptr's requester dropped: its burst ends and
    // the new winner starts counting from zero.
    always_comb begin
        w_cnt_base = (w_idx == r_ptr) ? r_cnt : '0;
        w_ptr_inc  = (r_ptr == LAST_IDX) ? '0 : r_ptr + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (w_load) begin
            if (w_any) begin
                if (w_cnt_base == BURST_LAST) begin
                    r_ptr <= w_next_idx;
                    r_cnt <= '0;
                end else begin
                    r_ptr <= w_idx;
                    r_cnt <= w_cnt_base + 8'd1;
                end
            end else if (r_cnt != '0) begin
                r_ptr <= w_ptr_inc;
                r_cnt <= '0;
            end
        end
    end
`else
    logic w_unused_max_burst;
    assign w_unused_max_burst = (MAX_BURST == 0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_load && w_any) begin
            r_ptr <= w_next_idx;
        end
    end
`endif

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule

// File: tb/tb_hd_rr_arbiter.sv
// Directed bench for hd_rr_arbiter (NUM_REQ=4, DATA_WIDTH=32); burst steps run when HD_ARB_BURST_EN is defined.
module tb_hd_rr_arbiter;
    import hd_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned NR = 4;

    logic             clk;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             out_valid;
    logic [DW-1:0]    out_data;
    logic [1:0]       out_src;
    logic             out_ready;

    int unsigned n_pass;
    int unsigned n_total;

    hd_rr_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .MAX_BURST  (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [1:0] src, input logic [31:0] data);
        check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        check({tag, ".src"}, {30'd0, out_src}, {30'd0, src});
        check({tag, ".data"}, out_data, data);
    endtask

    initial begin
        hd_idx_max_t exp_src;
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        out_ready = 1'b0;
        req_valid = '0;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 32'h100 + i;

        // Reset with random request activity
        for (int c = 0; c < 3; c++) begin
            req_valid = NR'($urandom_range(0, 15));
            out_ready = 1'($urandom_range(0, 1));
            #1;
            check("rst.ready", {28'd0, req_ready}, 32'd0);
            tick();
            check_out("rst", 1'b0, 2'd0, 32'd0);
        end

        rst       = 1'b0;
        req_valid = '0;
        out_ready = 1'b1;
        tick();
        check_out("idle", 1'b0, 2'd0, 32'd0);
        check("idle.ready", {28'd0, req_ready}, 32'd0);

`ifndef HD_ARB_BURST_EN
        // Full rotation, all requesters valid
        req_valid = 4'b1111;
        #1;
        check("rot.ready0", {28'd0, req_ready}, 32'h1);
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_src = 4'(i % 4);
            check_out("rot", 1'b1, exp_src[1:0], 32'h100 + (i % 4));
            check("rot.ready", {28'd0, req_ready}, 32'd1 << ((i + 1) % 4));
        end

        // Idle holds data/src, drops valid
        req_valid = '0;
        tick();
        check_out("hold", 1'b0, 2'd3, 32'h103);

        // Move ptr to 2 by granting req 1 alone
        req_valid = 4'b0010;
        #1;
        check("ptr2.ready", {28'd0, req_ready}, 32'h2);
        tick();
        check_out("ptr2", 1'b1, 2'd1, 32'h101);

        // Holes: only 1 and 3 valid, ptr=2 -> 3,1,3,1
        req_valid = 4'b1010;
        #1;
        check("holes.ready", {28'd0, req_ready}, 32'h8);
        tick(); check_out("holes0", 1'b1, 2'd3, 32'h103);
        tick(); check_out("holes1", 1'b1, 2'd1, 32'h101);
        tick(); check_out("holes2", 1'b1, 2'd3, 32'h103);
        tick(); check_out("holes3", 1'b1, 2'd1, 32'h101);

        // Backpressure for 5 cycles
        out_ready = 1'b0;
        #1;
        check("bp.ready", {28'd0, req_ready}, 32'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check_out("bp", 1'b1, 2'd1, 32'h101);
            check("bp.ready_hold", {28'd0, req_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp.release_ready", {28'd0, req_ready}, 32'h8);
        tick();
        check_out("bp.release", 1'b1, 2'd3, 32'h103);

        // Reset while a beat is stalled
        out_ready = 1'b0;
        rst       = 1'b1;
        #1;
        check("mrst.ready", {28'd0, req_ready}, 32'd0);
        tick();
        check_out("mrst", 1'b0, 2'd0, 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        check("mrst.post_ready", {28'd0, req_ready}, 32'h2);
        tick();
        check_out("mrst.post", 1'b1, 2'd1, 32'h101);
`else
        // Burst of 3 alternating between reqs 0 and 2
        req_valid = 4'b0101;
        #1;
        check("burst.ready0", {28'd0, req_ready}, 32'h1);
        tick(); check_out("burst0", 1'b1, 2'd0, 32'h100);
        tick(); check_out("burst1", 1'b1, 2'd0, 32'h100);
        tick(); check_out("burst2", 1'b1, 2'd0, 32'h100);
        tick(); check_out("burst3", 1'b1, 2'd2, 32'h102);
        tick(); check_out("burst4", 1'b1, 2'd2, 32'h102);
        tick(); check_out("burst5", 1'b1, 2'd2, 32'h102);
        tick(); check_out("burst6", 1'b1, 2'd0, 32'h100);

        // Req 0 drops after one beat: grant moves to 2 at once
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        req_valid = 4'b0101;
        tick();
        check_out("drop0", 1'b1, 2'd0, 32'h100);
        req_valid = 4'b0100;
        #1;
        check("drop.ready", {28'd0, req_ready}, 32'h4);
        tick();
        check_out("drop1", 1'b1, 2'd2, 32'h102);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
